// File: rtl/bus_latency_shaper.sv
// In-order request delay queue: holds up to Depth accepted host requests and releases
// each one after its own delay, never earlier than one cycle after its predecessor.
module bus_latency_shaper #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned Depth        = 4,
    parameter int unsigned CntWidth     = 6,
    parameter int unsigned MemDeviceIdx = 0,
    parameter int unsigned PeriphDelay  = 0,
    localparam int unsigned HostSelW    = NrHosts > 1 ? $clog2(NrHosts) : 1,
    localparam int unsigned DevSelW     = NrDevices > 1 ? $clog2(NrDevices) : 1,
    localparam int unsigned OccW        = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    host_req_i,
    output logic                    host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i,
    input  logic                    host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i,
    input  logic [DataWidth-1:0]    host_wdata_i,
    input  logic [HostSelW-1:0]     host_sel_i,
    input  logic [DevSelW-1:0]      device_sel_i,
    input  logic [CntWidth-1:0]     cfg_mem_delay_i,
    input  logic                    cfg_bypass_i,
    output logic                    dly_req_o,
    output logic [AddressWidth-1:0] dly_addr_o,
    output logic                    dly_we_o,
    output logic [DataWidth/8-1:0]  dly_be_o,
    output logic [DataWidth-1:0]    dly_wdata_o,
    output logic [HostSelW-1:0]     dly_host_sel_o,
    output logic [DevSelW-1:0]      dly_device_sel_o,
    output logic [OccW-1:0]         occupancy_o
);

    localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int unsigned BeW  = DataWidth / 8;

    logic [AddressWidth-1:0] addr_q  [Depth];
    logic                    we_q    [Depth];
    logic [BeW-1:0]          be_q    [Depth];
    logic [DataWidth-1:0]    wdata_q [Depth];
    logic [HostSelW-1:0]     hsel_q  [Depth];
    logic [DevSelW-1:0]      dsel_q  [Depth];
    logic [CntWidth-1:0]     cnt_q   [Depth];

    logic [PtrW-1:0] head_q, tail_q;
    logic [OccW-1:0] occ_q;
    logic            accept;
    logic            pop;
    logic [CntWidth-1:0] new_dly;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Grant depends on occupancy only, so a full queue refuses even while its head leaves.
    assign host_gnt_o  = rst_ni & (occ_q < OccW'(Depth));
    assign accept      = host_req_i & host_gnt_o;
    assign occupancy_o = occ_q;

    // Delay for the entry accepted this cycle and release condition for the head.
    always_comb begin
        new_dly = CntWidth'(PeriphDelay);
        if (cfg_bypass_i) begin
            new_dly = '0;
        end else if (device_sel_i == DevSelW'(MemDeviceIdx)) begin
            new_dly = cfg_mem_delay_i;
        end
        pop = (occ_q != '0) && (cnt_q[head_q] == '0);
    end

    // Control state: pointers, occupancy, per-entry counters and registered release outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q           <= '0;
            tail_q           <= '0;
            occ_q            <= '0;
            dly_req_o        <= 1'b0;
            dly_addr_o       <= '0;
            dly_we_o         <= 1'b0;
            dly_be_o         <= '0;
            dly_wdata_o      <= '0;
            dly_host_sel_o   <= '0;
            dly_device_sel_o <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // Every counter runs down independently; a fresh accept overrides its slot.
            for (int unsigned i = 0; i < Depth; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (accept) begin
                cnt_q[tail_q] <= new_dly;
                tail_q        <= ptr_inc(tail_q);
            end
            dly_req_o <= pop;
            if (pop) begin
                dly_addr_o       <= addr_q[head_q];
                dly_we_o         <= we_q[head_q];
                dly_be_o         <= be_q[head_q];
                dly_wdata_o      <= wdata_q[head_q];
                dly_host_sel_o   <= hsel_q[head_q];
                dly_device_sel_o <= dsel_q[head_q];
                head_q           <= ptr_inc(head_q);
            end else begin
                dly_addr_o       <= '0;
                dly_we_o         <= 1'b0;
                dly_be_o         <= '0;
                dly_wdata_o      <= '0;
                dly_host_sel_o   <= '0;
                dly_device_sel_o <= '0;
            end
            if (accept && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (!accept && pop) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    // Payload storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q[tail_q]  <= host_addr_i;
            we_q[tail_q]    <= host_we_i;
            be_q[tail_q]    <= host_be_i;
            wdata_q[tail_q] <= host_wdata_i;
            hsel_q[tail_q]  <= host_sel_i;
            dsel_q[tail_q]  <= device_sel_i;
        end
    end

endmodule
